// File: rtl/int_adder_pipe.sv
// Pipelined integer adder/subtractor.
// An input register captures each operand set; slice k of the sum is then
// formed in pipeline stage k from the carry registered by slice k-1. Operand
// bits still to be consumed and sum bits already formed travel with the set,
// so every slice stage works on full-width vectors masked to its own bits.
// A single advance signal moves every stage at once, which gives
// backpressure without a skid buffer.
module int_adder_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  carry_in,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero
);

    // DATA_WIDTH must be a whole multiple of NUM_STAGES.
    localparam int SW   = DATA_WIDTH / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;
    localparam logic [DATA_WIDTH:0] ONE        = {{DATA_WIDTH{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0] SLICE_ONES = (ONE << SW) - ONE;

    // Stage k holds the operand set that slice k works on during this cycle.
    // b_q already holds ~data_b and c_q the inverted borrow when subtracting,
    // so every slice is a plain adder.
    logic                  v_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] a_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] s_q [NUM_STAGES];
    logic                  c_q [NUM_STAGES];

    logic [DATA_WIDTH-1:0] s_nxt [NUM_STAGES];
    logic                  c_nxt [NUM_STAGES];

    logic                  advance;
    logic                  ovf_nxt;
    logic                  zero_nxt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        localparam logic [DATA_WIDTH-1:0] MASK  = DATA_WIDTH'(SLICE_ONES << (k * SW));
        localparam logic [DATA_WIDTH:0]   CMASK = ONE << ((k + 1) * SW);

        logic [DATA_WIDTH:0] t;

        // Only the bits under MASK take part in the sum; the carry out of the
        // slice lands on the bit just above it and is picked up through CMASK.
        assign t = {1'b0, a_q[k] & MASK} + {1'b0, b_q[k] & MASK}
                 + ({{DATA_WIDTH{1'b0}}, c_q[k]} << (k * SW));
        assign s_nxt[k] = (s_q[k] & ~MASK) | (t[DATA_WIDTH-1:0] & MASK);
        assign c_nxt[k] = |(t & CMASK);
    end

    assign ovf_nxt  = (a_q[LAST][DATA_WIDTH-1] == b_q[LAST][DATA_WIDTH-1])
                   && (s_nxt[LAST][DATA_WIDTH-1] != a_q[LAST][DATA_WIDTH-1]);
    assign zero_nxt = (s_nxt[LAST] == '0);

    // Input register and inter-slice skew registers, all moving on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                a_q[0] <= data_a;
                b_q[0] <= sub ? ~data_b : data_b;
                s_q[0] <= '0;
                c_q[0] <= carry_in ^ sub;
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                    s_q[k] <= s_nxt[k-1];
                    c_q[k] <= c_nxt[k-1];
                end
            end
        end
    end

    // Result register fed by the last slice; keeps the last result on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= v_q[LAST];
            if (v_q[LAST]) begin
                sum       <= s_nxt[LAST];
                carry_out <= c_nxt[LAST];
                overflow  <= ovf_nxt;
                zero      <= zero_nxt;
            end
        end
    end

endmodule

// File: tb/tb_int_adder_pipe.sv
// Scoreboard bench for int_adder_pipe (32 bits, 4 slices).
module tb_int_adder_pipe;

    localparam int DW = 32;
    localparam int NS = 4;

    typedef struct {
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        int            cyc;
        bit            chk_lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          carry_in;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum;
    logic          carry_out;
    logic          overflow;
    logic          zero;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   out_cyc[$];

    int_adder_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(logic [DW-1:0] s, logic c, logic o, logic z, bit lat);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.cyc = 0; e.chk_lat = lat;
        return e;
    endfunction

    // Reference: exact wide arithmetic, signed range test for overflow.
    function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic cin, logic op_sub);
        logic [DW:0] r;
        longint      sa, sb, sr;
        int          ci;
        logic        c;
        sa = $signed(a);
        sb = $signed(b);
        ci = int'(cin);
        if (!op_sub) begin
            r  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            c  = r[DW];
            sr = sa + sb + ci;
        end else begin
            r  = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
            c  = ~r[DW];
            sr = sa - sb - ci;
        end
        return mk(r[DW-1:0], c, (sr > 64'sd2147483647) || (sr < -64'sd2147483648),
                  r[DW-1:0] == '0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic op_sub, input exp_t e,
                        output int tries);
        bit acc;
        in_valid = 1'b1; data_a = a; data_b = b; carry_in = cin; sub = op_sub;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 1000) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.cyc = cyc;
                exp_q.push_back(e);
            end
            tries++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'(tries), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int            tries;
        bit            rand_done;
        bit            prev_stall;
        logic [35:0]   prev_out;
        logic [DW-1:0] ra, rb;
        logic          rc, rs;

        rst_n = 1'b0; in_valid = 1'b0; data_a = '0; data_b = '0;
        carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        prev_stall = 1'b0; prev_out = '0;

        // Output monitor: pops the scoreboard on every consumed result.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall)
                        chk("stall_hold", {28'd0, out_valid, carry_out, overflow, zero, sum},
                            {28'd0, prev_out});
                    if (out_valid && !out_ready)
                        chk("in_ready_stall", 64'(in_ready), 64'd0);
                    if (out_valid && out_ready) begin
                        out_cyc.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", {29'd0, carry_out, overflow, zero, sum}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("result", {29'd0, carry_out, overflow, zero, sum},
                                {29'd0, e.cout, e.ovf, e.zero, e.sum});
                            if (e.chk_lat)
                                chk("latency", 64'(cyc - e.cyc), 64'(NS + 1));
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_out   = {out_valid, carry_out, overflow, zero, sum};
                end
            end
        join_none

        // Reset state.
        #1;
        chk("reset_out", {28'd0, out_valid, carry_out, overflow, zero, sum}, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed corner cases, first set right after reset release.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1, 0, 1, 1), tries);
        chk("first_accept_tries", 64'(tries), 64'd1);
        send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h8000_0000, 0, 1, 0, 1), tries);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 0, 0, 0, 1), tries);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, mk(32'h0000_0001, 1, 0, 0, 1), tries);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1, 1, 0, 1), tries);
        drain();

        // Bubbles: alternate valid for 6 cycles.
        out_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            send(ra, rb, 1'b0, 1'b0, mk(ra + rb, ({1'b0, ra} + {1'b0, rb}) >> DW, 0, 0, 1) , tries);
            exp_q[exp_q.size()-1] = model(ra, rb, 1'b0, 1'b0);
            exp_q[exp_q.size()-1].chk_lat = 1'b1;
            exp_q[exp_q.size()-1].cyc = cyc - 1;
            idle(1);
        end
        drain();
        chk("bubble_count", 64'(out_cyc.size()), 64'd3);
        if (out_cyc.size() == 3) begin
            chk("bubble_gap1", 64'(out_cyc[1] - out_cyc[0]), 64'd2);
            chk("bubble_gap2", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
        end

        // Back-to-back with a 3-cycle downstream stall.
        out_cyc.delete();
        fork
            for (int i = 0; i < 8; i++) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
                send(ra, rb, rc, rs, model(ra, rb, rc, rs), tries);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(out_cyc.size()), 64'd8);

        // Random traffic with random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    case ($urandom_range(0, 4))
                        0: ra = 32'hFFFF_FFFF;
                        1: ra = 32'h8000_0000;
                        2: ra = 32'h7FFF_FFFF;
                        default: ra = $urandom;
                    endcase
                    case ($urandom_range(0, 4))
                        0: rb = 32'hFFFF_FFFF;
                        1: rb = 32'h0000_0000;
                        2: rb = ra;
                        default: rb = $urandom;
                    endcase
                    rc = 1'($urandom); rs = 1'($urandom);
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs), tries);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with sets in flight.
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(32'h0, 1, 1, 1, 1), tries);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 0, 0, 0, 1), tries);
        send(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, mk(32'h0000_0101, 0, 0, 0, 1), tries);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_out", {28'd0, out_valid, carry_out, overflow, zero, sum}, 64'd0);
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        out_cyc.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 0, 0, 0, 1), tries);
        chk("post_reset_tries", 64'(tries), 64'd1);
        idle(10);
        chk("post_reset_outputs", 64'(out_cyc.size()), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_adder_pipe.md
INT_ADDER_PIPE -- requirements
Module: int_adder_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter NUM_STAGES, default 4: number of pipeline slices; DATA_WIDTH SHALL be an integer multiple of NUM_STAGES; legal range 1..DATA_WIDTH.
REQ-003 clk  input  1  the single clock; every register SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set on data_a/data_b/carry_in/sub is valid.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 data_a  input  DATA_WIDTH  first operand.
REQ-008 data_b  input  DATA_WIDTH  second operand.
REQ-009 carry_in  input  1  carry in for add, borrow in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result fields are valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  DATA_WIDTH  result.
REQ-014 carry_out  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-015 overflow  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 The transfer rule SHALL be: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-018 Add: {carry_out,sum} = data_a + data_b + carry_in, modulo 2^(DATA_WIDTH+1).
REQ-019 Subtract: {carry_out,sum} = data_a + ~data_b + ~carry_in, i.e. data_a - data_b - carry_in.
REQ-020 The datapath SHALL be split into NUM_STAGES slices of DATA_WIDTH/NUM_STAGES bits each; slice k SHALL add bits of slice k in pipeline stage k using the carry registered from slice k-1.
REQ-021 Operand bits not yet consumed and result bits already produced SHALL travel with the operand set through skew registers, so that all results are bit-exact to REQ-018/REQ-019.
REQ-022 overflow SHALL equal (a_msb == b'_msb) && (sum_msb != a_msb), where b' is data_b for add and ~data_b for subtract.
REQ-023 zero SHALL be computed from the full final sum in the last stage.
REQ-024 Latency SHALL be exactly NUM_STAGES cycles: a set accepted at edge N produces out_valid high after edge N+NUM_STAGES when not stalled.
REQ-025 Each stage SHALL carry a valid bit; advance = !out_valid || out_ready; all stages SHALL shift only on advance; in_ready SHALL equal advance.
REQ-026 Throughput SHALL be one result per cycle with out_ready held high.
REQ-027 During stall (out_valid && !out_ready) sum, carry_out, overflow, zero and out_valid SHALL hold stable, and no set in flight SHALL be lost, duplicated or reordered.
REQ-028 Bubbles (in_valid low on an accepted cycle) SHALL propagate as invalid stages and SHALL NOT produce out_valid.
REQ-029 Simultaneous output consumption and input acceptance in one cycle SHALL be lossless.
REQ-030 NUM_STAGES = 1 SHALL give a single registered full-width adder with latency 1.

Reset
REQ-031 rst_n low SHALL immediately clear all stage valid bits and drive out_valid=0, sum=0, carry_out=0, overflow=0, zero=0, independent of clk.
REQ-032 During reset in_ready SHALL be 1; the first set after deassertion SHALL be accepted at the first rising edge with rst_n high.
REQ-033 Reset mid-operation SHALL discard every set in flight; none SHALL appear at the output after reset.

Verification (DATA_WIDTH=32, NUM_STAGES=4, out_ready=1 unless stated)
REQ-034 Add 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, carry_out=1, zero=1, overflow=0, out_valid exactly 4 cycles after acceptance.
REQ-035 Add 0x7FFFFFFF + 0x00000000, cin=1 -> sum=0x80000000, carry_out=0, overflow=1, zero=0.
REQ-036 Subtract 0x00000005 - 0x00000007, cin=0 -> sum=0xFFFFFFFE, carry_out=0, overflow=0; subtract 7-5 cin=1 -> sum=0x00000001, carry_out=1.
REQ-037 Issue 8 back-to-back sets, drop out_ready for 3 cycles mid-stream -> in_ready low during stall, outputs held, all 8 results emerge in order, none repeated.
REQ-038 Alternate in_valid 1/0 for 6 cycles -> exactly 3 results, each spaced 2 cycles apart.
REQ-039 Accept 3 sets, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and all outputs 0 immediately; no result appears after release.
